// File: rtl/nco_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_pkg                                                      |
// | Description : Shared constants, quadrant encoding and quarter-wave table   |
// |               generation for the quadrature NCO.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nco_pkg;

    localparam int c_ACC_WIDTH      = 32;
    localparam int c_LUT_ADDR_WIDTH = 8;
    localparam int c_OUT_WIDTH      = 16;

    // Default table depth (N) and peak amplitude (A)
    localparam int c_N = 1 << (c_LUT_ADDR_WIDTH - 2);
    localparam int c_A = (1 << (c_OUT_WIDTH - 1)) - 1;

    // Quadrant = top two bits of the full-cycle lookup address
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    // Q1.15 gain: unity, rounding constant and shift
    localparam logic [15:0] c_GAIN_UNITY = 16'd32768;
    localparam int          c_ROUND      = 1 << 14;
    localparam int          c_GAIN_SHIFT = 15;

    localparam real c_PI = 3.14159265358979323846;

    // Quarter-wave entry with half-sample offset, so no entry is ever zero:
    // round(A * sin(2*pi*(k+0.5)/2^addr_w)); argument is in the first quadrant.
    function automatic int lut_value(input int k, input int addr_w, input int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 2.0 * c_PI * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_iq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_iq_if                                                    |
// | Description : Control, configuration and sample bus of the quadrature NCO. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface nco_iq_if #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16
);
    logic                        step_in;
    logic                        phase_clr_in;
    logic                        cfg_valid_in;
    logic [ACC_WIDTH-1:0]        fcw_in;
    logic [ACC_WIDTH-1:0]        phase_off_in;
    logic [15:0]                 gain_in;
    logic signed [OUT_WIDTH-1:0] i_out;
    logic signed [OUT_WIDTH-1:0] q_out;
    logic                        valid_out;

    // Controller side
    modport master (
        output step_in, phase_clr_in, cfg_valid_in, fcw_in, phase_off_in, gain_in,
        input  i_out, q_out, valid_out
    );

    // Oscillator side
    modport slave (
        input  step_in, phase_clr_in, cfg_valid_in, fcw_in, phase_off_in, gain_in,
        output i_out, q_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/nco_quarter_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_quarter_lut                                              |
// | Description : Dual-read-port synchronous quarter-wave sine ROM, one-cycle  |
// |               read latency, contents built at elaboration.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = c_LUT_ADDR_WIDTH,
    parameter int OUT_WIDTH      = c_OUT_WIDTH
) (
    input  wire logic                      clk_in,
    input  wire logic                      rst_n_in,
    input  wire logic [LUT_ADDR_WIDTH-3:0] i_addr_i,
    input  wire logic [LUT_ADDR_WIDTH-3:0] i_addr_q,
    output logic      [OUT_WIDTH-2:0]      o_mag_i,
    output logic      [OUT_WIDTH-2:0]      o_mag_q
);
    localparam int c_ENTRIES = 1 << (LUT_ADDR_WIDTH - 2);
    localparam int c_MAG_W   = OUT_WIDTH - 1;

    logic [c_MAG_W-1:0] w_rom [c_ENTRIES];

    generate
        for (genvar k = 0; k < c_ENTRIES; k++) begin : g_rom
            assign w_rom[k] = c_MAG_W'(lut_value(k, LUT_ADDR_WIDTH, OUT_WIDTH));
        end
    endgenerate

    // Registered read of both ports
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            o_mag_i <= '0;
            o_mag_q <= '0;
        end else begin
            o_mag_i <= w_rom[i_addr_i];
            o_mag_q <= w_rom[i_addr_q];
        end
    end
endmodule
`default_nettype wire

// File: rtl/nco_iq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_iq                                                       |
// | Description : Quadrature NCO: phase accumulator, quarter-wave lookup,      |
// |               Q1.15 gain with round-half-up, 4-cycle fixed latency.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nco_iq
    import nco_pkg::*;
#(
    parameter int                   ACC_WIDTH      = c_ACC_WIDTH,
    parameter int                   LUT_ADDR_WIDTH = c_LUT_ADDR_WIDTH,
    parameter int                   OUT_WIDTH      = c_OUT_WIDTH,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_FCW    = ACC_WIDTH'(32'd582_397_566),
    parameter logic [ACC_WIDTH-1:0] DEFAULT_PHASE  = ACC_WIDTH'(32'h4000_0000)
) (
    input wire logic clk_in,
    input wire logic rst_n_in,
    nco_iq_if.slave  bus
);
    localparam int c_KW      = LUT_ADDR_WIDTH - 2;
    localparam int c_SHIFT   = ACC_WIDTH - LUT_ADDR_WIDTH;
    localparam int c_QUARTER = 1 << c_KW;
    localparam int c_PROD_W  = OUT_WIDTH + 17;

    // Signed raw sample times unsigned gain, round half up, arithmetic shift.
    function automatic logic signed [OUT_WIDTH-1:0] scale(
        input logic signed [OUT_WIDTH-1:0] raw,
        input logic        [15:0]          g
    );
        logic signed [c_PROD_W-1:0] prod;
        prod = c_PROD_W'(raw) * c_PROD_W'($signed({1'b0, g}));
        return OUT_WIDTH'((prod + c_PROD_W'(c_ROUND)) >>> c_GAIN_SHIFT);
    endfunction

    // ---------------- stage 0: phase sample and address ----------------
    logic [ACC_WIDTH-1:0]      r_acc, r_fcw, r_poff, w_phase;
    logic [15:0]               r_gain, w_gain_clamp;
    logic [LUT_ADDR_WIDTH-1:0] w_addr_q, w_addr_i;

    assign w_phase      = bus.phase_clr_in ? '0 : r_acc;
    assign w_gain_clamp = (bus.gain_in > c_GAIN_UNITY) ? c_GAIN_UNITY : bus.gain_in;
    assign w_addr_q     = LUT_ADDR_WIDTH'((w_phase + r_poff) >> c_SHIFT);
    assign w_addr_i     = w_addr_q + LUT_ADDR_WIDTH'(c_QUARTER);

    // Accumulator advance and configuration load (new config applies to the next step)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc  <= '0;
            r_fcw  <= DEFAULT_FCW;
            r_poff <= DEFAULT_PHASE;
            r_gain <= c_GAIN_UNITY;
        end else begin
            r_acc <= w_phase + (bus.step_in ? r_fcw : '0);
            if (bus.cfg_valid_in) begin
                r_fcw  <= bus.fcw_in;
                r_poff <= bus.phase_off_in;
                r_gain <= w_gain_clamp;
            end
        end
    end

    // ---------------- stage 1: registered address ----------------
    logic                      r_vld1;
    logic [LUT_ADDR_WIDTH-1:0] r_a_i, r_a_q;
    logic [15:0]               r_g1;

    // Launch: capture address and the gain in force for this sample
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld1 <= 1'b0;
            r_a_i  <= '0;
            r_a_q  <= '0;
            r_g1   <= '0;
        end else begin
            r_vld1 <= bus.step_in;
            r_a_i  <= w_addr_i;
            r_a_q  <= w_addr_q;
            r_g1   <= r_gain;
        end
    end

    // Quadrant fold: odd quadrants read the table mirrored, upper half is negated
    quad_t             w_quad_i, w_quad_q;
    logic [c_KW-1:0]   w_k_i, w_k_q;
    logic              w_neg_i, w_neg_q;

    assign w_quad_i = quad_t'(r_a_i[LUT_ADDR_WIDTH-1 -: 2]);
    assign w_quad_q = quad_t'(r_a_q[LUT_ADDR_WIDTH-1 -: 2]);
    assign w_k_i    = (w_quad_i == QUAD_1 || w_quad_i == QUAD_3) ? ~r_a_i[c_KW-1:0] : r_a_i[c_KW-1:0];
    assign w_k_q    = (w_quad_q == QUAD_1 || w_quad_q == QUAD_3) ? ~r_a_q[c_KW-1:0] : r_a_q[c_KW-1:0];
    assign w_neg_i  = (w_quad_i == QUAD_2 || w_quad_i == QUAD_3);
    assign w_neg_q  = (w_quad_q == QUAD_2 || w_quad_q == QUAD_3);

    // ---------------- stage 2: table read ----------------
    logic [OUT_WIDTH-2:0] w_mag_i, w_mag_q;

    nco_quarter_lut #(
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH)
    ) u_lut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_addr_i (w_k_i),
        .i_addr_q (w_k_q),
        .o_mag_i  (w_mag_i),
        .o_mag_q  (w_mag_q)
    );

    logic        r_vld2, r_neg2_i, r_neg2_q;
    logic [15:0] r_g2;

    // Carry sign, gain and valid alongside the table read
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld2   <= 1'b0;
            r_neg2_i <= 1'b0;
            r_neg2_q <= 1'b0;
            r_g2     <= '0;
        end else begin
            r_vld2   <= r_vld1;
            r_neg2_i <= w_neg_i;
            r_neg2_q <= w_neg_q;
            r_g2     <= r_g1;
        end
    end

    // ---------------- stage 3: apply quadrant sign ----------------
    logic                        r_vld3;
    logic signed [OUT_WIDTH-1:0] r_raw_i, r_raw_q;
    logic [15:0]                 r_g3;

    // Signed raw sample from magnitude and quadrant sign
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld3  <= 1'b0;
            r_raw_i <= '0;
            r_raw_q <= '0;
            r_g3    <= '0;
        end else begin
            r_vld3  <= r_vld2;
            r_raw_i <= r_neg2_i ? -$signed({1'b0, w_mag_i}) : $signed({1'b0, w_mag_i});
            r_raw_q <= r_neg2_q ? -$signed({1'b0, w_mag_q}) : $signed({1'b0, w_mag_q});
            r_g3    <= r_g2;
        end
    end

    // ---------------- stage 4: gain, rounding, output ----------------
    logic                        r_valid_out;
    logic signed [OUT_WIDTH-1:0] r_i_out, r_q_out;

    // Outputs update only on a valid sample and hold otherwise
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid_out <= 1'b0;
            r_i_out     <= '0;
            r_q_out     <= '0;
        end else begin
            r_valid_out <= r_vld3;
            if (r_vld3) begin
                r_i_out <= scale(r_raw_i, r_g3);
                r_q_out <= scale(r_raw_q, r_g3);
            end
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.i_out     = r_i_out;
    assign bus.q_out     = r_q_out;
endmodule
`default_nettype wire

// File: tb/tb_nco_iq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nco_iq                                                    |
// | Description : Self-checking bench for nco_iq with expected-sample queue.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nco_iq;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    typedef struct {
        int ei;
        int eq;
    } exp_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    nco_iq_if #(.ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) bus ();

    nco_iq #(
        .ACC_WIDTH      (ACC_W),
        .LUT_ADDR_WIDTH (8),
        .OUT_WIDTH      (OUT_W),
        .DEFAULT_FCW    (32'd582_397_566),
        .DEFAULT_PHASE  (32'h4000_0000)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_pushed  = 0;
    int          n_strobes = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] m_acc, m_fcw, m_poff;
    int          m_gain;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    // Full-cycle reference: round-half-away of A*sin(2*pi*(a+0.5)/256)
    function automatic int ref_raw(input int a);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(a & 255) + 0.5) / 256.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int scale(input int raw, input int g);
        longint p;
        p = longint'(raw) * longint'(g) + 64'sd16384;
        return int'(p >>> 15);
    endfunction

    task automatic model_reset();
        m_acc  = 32'd0;
        m_fcw  = 32'd582_397_566;
        m_poff = 32'h4000_0000;
        m_gain = 32768;
    endtask

    // One clock of stimulus; a step pushes either the hand value or the model value
    task automatic cyc(input bit step, input bit clr, input bit cfg,
                       input logic [31:0] fcw, input logic [31:0] poff, input int gain,
                       input bit hand, input int hi, input int hq);
        logic [31:0] p, ph, nxt;
        int          a;
        exp_t        e;
        bus.step_in      = step;
        bus.phase_clr_in = clr;
        bus.cfg_valid_in = cfg;
        bus.fcw_in       = fcw;
        bus.phase_off_in = poff;
        bus.gain_in      = gain[15:0];
        p = clr ? 32'd0 : m_acc;
        if (step) begin
            ph = p + m_poff;
            a  = int'(ph >> 24);
            if (hand) e = '{hi, hq};
            else      e = '{scale(ref_raw(a + 64), m_gain), scale(ref_raw(a), m_gain)};
            sb.push_back(e);
            n_pushed++;
        end
        nxt = p + (step ? m_fcw : 32'd0);
        if (cfg) begin
            m_fcw  = fcw;
            m_poff = poff;
            m_gain = (gain > 32768) ? 32768 : gain;
        end
        @(posedge clk_in);
        #1;
        m_acc = nxt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    // Compare every strobed sample against the head of the expected queue
    always @(negedge clk_in) begin
        if (bus.valid_out) begin
            n_strobes++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe i %0d q %0d required no strobe",
                         int'(bus.i_out), int'(bus.q_out));
            end else begin
                mon_e = sb.pop_front();
                chk("i_out", int'(bus.i_out), mon_e.ei);
                chk("q_out", int'(bus.q_out), mon_e.eq);
            end
        end
    end

    initial begin
        bus.step_in      = 1'b0;
        bus.phase_clr_in = 1'b0;
        bus.cfg_valid_in = 1'b0;
        bus.fcw_in       = '0;
        bus.phase_off_in = '0;
        bus.gain_in      = '0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_i_out", int'(bus.i_out), 0);
        chk("reset_q_out", int'(bus.q_out), 0);
        chk("reset_valid", int'(bus.valid_out), 0);
        rst_n_in = 1'b1;

        // Phase 0, zero offset
        cyc(0, 0, 1, 32'd0, 32'd0, 32768, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 32765, 402);
        idle(5);

        // Gain and rounding
        cyc(0, 0, 1, 32'd0, 32'd0, 16384, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 16383, 201);
        cyc(0, 0, 1, 32'd0, 32'h8000_0000, 16384, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, -16382, -201);
        cyc(0, 0, 1, 32'd0, 32'd0, 65535, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 32765, 402);
        idle(5);
        chk("hold_i_out", int'(bus.i_out), 32765);
        chk("hold_q_out", int'(bus.q_out), 402);

        // Config and clear coinciding with steps
        cyc(0, 0, 1, 32'h0100_0000, 32'd0, 32768, 0, 0, 0);
        cyc(0, 1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h0200_0000, 32'd0, 32768, 1, 32765, 402);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 32745, 1206);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        cyc(1, 1, 0, 32'd0, 32'd0, 0, 1, 32765, 402);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        idle(6);

        // Full-cycle sweep, one address per step
        cyc(0, 0, 1, 32'h0100_0000, 32'd0, 32768, 0, 0, 0);
        cyc(0, 1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        for (int s = 0; s < 256; s++) cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        idle(6);

        // Accumulator wrap-around
        cyc(0, 0, 1, 32'hFFFF_FFFF, 32'd0, 32768, 0, 0, 0);
        cyc(0, 1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 32765, 402);
        for (int s = 0; s < 3; s++) cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 32765, -402);
        idle(6);

        // Reset in the middle of a burst: in-flight samples are dropped
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        rst_n_in     = 1'b0;
        bus.step_in  = 1'b0;
        n_pushed     = n_pushed - sb.size();
        sb.delete();
        model_reset();
        #2;
        chk("midrst_i_out", int'(bus.i_out), 0);
        chk("midrst_q_out", int'(bus.q_out), 0);
        chk("midrst_valid", int'(bus.valid_out), 0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idle(6);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, -402, 32765);
        cyc(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        idle(2);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk_in);
        #1;
        chk("queue_drained", sb.size(), 0);
        chk("strobe_count", n_strobes, n_pushed);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
